// File: rtl/load_store_unit.sv
// Load/store unit: takes the effective address, store data and func3 from the
// ALU stage and runs one memory access over a req/gnt/rvalid handshake.
// Load results are returned sign- or zero-extended. busy stalls the core while
// an access is outstanding.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    localparam logic [1:0] FC_NONE      = 2'b00;
    localparam logic [1:0] FC_MISALIGN  = 2'b01;
    localparam logic [1:0] FC_ILLEGAL   = 2'b10;
    localparam logic [1:0] FC_TIMEOUT   = 2'b11;

    // A zero timeout disables the abort path; otherwise the counter runs
    // 0..TIMEOUT_CYCLES-1 and the last count without a response aborts.
    localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_load_q;
    logic [2:0]       func3_q;
    logic [1:0]       lane_q;

    logic             is_load;
    logic             is_store;
    logic             illegal;
    logic             misaligned;
    logic [3:0]       wstrb_n;
    logic [31:0]      wdata_n;

    logic [7:0]       rbyte;
    logic [15:0]      rhalf;
    logic [31:0]      ext_data;

    // Decode the incoming request: classify the opcode, check func3 and
    // alignment, and build the lane-replicated write data and byte strobes.
    always_comb begin
        is_load    = (opcode == OP_LOAD);
        is_store   = (opcode == OP_STORE);
        illegal    = 1'b0;
        misaligned = 1'b0;
        wstrb_n    = 4'b0000;
        wdata_n    = 32'h0;

        if (is_load) begin
            illegal = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
        end else begin
            illegal = func3[2] || (func3[1:0] == 2'b11);
        end

        case (func3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        case (func3[1:0])
            2'b00: begin
                wdata_n = {4{store_data[7:0]}};
                wstrb_n = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                wdata_n = {2{store_data[15:0]}};
                wstrb_n = 4'b0011 << addr[1:0];
            end
            default: begin
                wdata_n = store_data;
                wstrb_n = 4'b1111;
            end
        endcase
    end

    // Pick the addressed byte/halfword out of the returned word and extend it
    // according to the latched func3.
    always_comb begin
        case (lane_q)
            2'd0:    rbyte = mem_rdata[7:0];
            2'd1:    rbyte = mem_rdata[15:8];
            2'd2:    rbyte = mem_rdata[23:16];
            default: rbyte = mem_rdata[31:24];
        endcase
        rhalf = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (func3_q)
            3'b000:  ext_data = {{24{rbyte[7]}}, rbyte};
            3'b100:  ext_data = {24'h0, rbyte};
            3'b001:  ext_data = {{16{rhalf[15]}}, rhalf};
            3'b101:  ext_data = {16'h0, rhalf};
            default: ext_data = mem_rdata;
        endcase
    end

    // Access sequencer: accepts a request, faults it on decode or runs the
    // memory handshake, and registers every output it drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            is_load_q  <= 1'b0;
            func3_q    <= 3'b000;
            lane_q     <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            load_data  <= 32'h0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wstrb  <= 4'b0000;
            mem_wdata  <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (is_load || is_store)) begin
                        is_load_q  <= is_load;
                        func3_q    <= func3;
                        lane_q     <= addr[1:0];
                        busy       <= 1'b1;
                        fault      <= 1'b0;
                        fault_code <= FC_NONE;
                        if (illegal) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            fault      <= 1'b1;
                            fault_code <= FC_ILLEGAL;
                        end else if (misaligned) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            fault      <= 1'b1;
                            fault_code <= FC_MISALIGN;
                        end else begin
                            state     <= REQ;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wstrb <= is_store ? wstrb_n : 4'b0000;
                            mem_wdata <= is_store ? wdata_n : 32'h0;
                        end
                    end
                end

                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        if (is_load_q) begin
                            state <= WAIT_R;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else if (TO_EN && (cnt == TO_LAST)) begin
                        mem_req    <= 1'b0;
                        state      <= DONE;
                        done       <= 1'b1;
                        fault      <= 1'b1;
                        fault_code <= FC_TIMEOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_R: begin
                    if (mem_rvalid) begin
                        load_data <= ext_data;
                        state     <= DONE;
                        done      <= 1'b1;
                    end else if (TO_EN && (cnt == TO_LAST)) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        fault      <= 1'b1;
                        fault_code <= FC_TIMEOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    fault      <= 1'b0;
                    fault_code <= FC_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit. A small byte-lane memory answers the
// main instance with zero-wait grants (optionally stalled); a second instance
// with a short timeout never receives a grant.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start2;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] store_data;

    logic        busy, done, fault;
    logic [1:0]  fault_code;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    logic        busy2, done2, fault2;
    logic [1:0]  fault_code2;
    logic [31:0] load_data2;
    logic        mem_req2, mem_we2;
    logic [31:0] mem_addr2, mem_wdata2;
    logic [3:0]  mem_wstrb2;

    logic        hold_gnt;
    logic        hold_rvalid;
    logic        stray_rvalid;
    logic        rv_q;
    logic [31:0] rd_q;
    logic [31:0] mem [0:255];

    int          checks;
    int          errors;

    int          lat;
    logic        flt;
    logic [1:0]  code;
    logic        saw_req;
    logic [31:0] req_addr;
    logic [3:0]  req_strb;
    logic [31:0] req_wdata;
    logic        req_we;

    localparam logic [4:0] OP_LD = 5'b00000;
    localparam logic [4:0] OP_ST = 5'b01000;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .func3(func3),
        .addr(addr), .store_data(store_data), .busy(busy), .done(done),
        .fault(fault), .fault_code(fault_code), .load_data(load_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut_to (
        .clk(clk), .rst_n(rst_n), .start(start2), .opcode(opcode), .func3(func3),
        .addr(addr), .store_data(store_data), .busy(busy2), .done(done2),
        .fault(fault2), .fault_code(fault_code2), .load_data(load_data2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wstrb(mem_wstrb2), .mem_wdata(mem_wdata2), .mem_gnt(1'b0),
        .mem_rvalid(1'b0), .mem_rdata(32'h0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grant any request in the same cycle unless stalled.
    assign mem_gnt    = mem_req & ~hold_gnt;
    assign mem_rvalid = (rv_q & ~hold_rvalid) | stray_rvalid;
    assign mem_rdata  = stray_rvalid ? 32'hDEADBEEF : rd_q;

    // Memory model: writes land on granted stores by strobe, reads return one cycle after grant.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_q <= 1'b0;
            rd_q <= 32'h0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else begin
            rv_q <= mem_req & mem_gnt & ~mem_we;
            rd_q <= mem[mem_addr[9:2]];
            if (mem_req && mem_gnt && mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issue one access on the main instance and follow it to its done pulse.
    // lat counts cycles from the start cycle; 99 means done never came.
    task automatic applyStimulus(input logic [4:0] op, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d);
        bit got_done;
        @(posedge clk); #1;
        opcode = op; func3 = f3; addr = a; store_data = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; saw_req = 1'b0; got_done = 1'b0;
        flt = 1'b0; code = 2'b00;
        req_addr = 32'h0; req_strb = 4'h0; req_wdata = 32'h0; req_we = 1'b0;
        while (lat < 40 && !got_done) begin
            @(negedge clk);
            if (mem_req && !saw_req) begin
                saw_req   = 1'b1;
                req_addr  = mem_addr;
                req_strb  = mem_wstrb;
                req_wdata = mem_wdata;
                req_we    = mem_we;
            end
            if (done) begin
                got_done = 1'b1;
                flt      = fault;
                code     = fault_code;
            end else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        if (!got_done) lat = 99;
    endtask

    initial begin
        int reqs;
        checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        opcode = 5'b0; func3 = 3'b0; addr = 32'h0; store_data = 32'h0;
        hold_gnt = 1'b0; hold_rvalid = 1'b0; stray_rvalid = 1'b0;

        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_fault_code", fault_code, 0);
        checkOutput("rst_load_data", load_data, 0);
        checkOutput("rst_wstrb", mem_wstrb, 0);
        @(negedge clk); rst_n = 1'b1;

        applyStimulus(OP_ST, 3'b010, 32'h0, 32'h80FF7F01);
        checkOutput("sw_latency", lat, 2);
        checkOutput("sw_fault", flt, 0);
        checkOutput("sw_wstrb", req_strb, 4'hF);

        applyStimulus(OP_LD, 3'b000, 32'h3, 32'h0);
        checkOutput("lb_latency", lat, 3);
        checkOutput("lb_fault", flt, 0);
        checkOutput("lb_data", load_data, 32'hFFFFFF80);

        applyStimulus(OP_LD, 3'b100, 32'h2, 32'h0);
        checkOutput("lbu_data", load_data, 32'h000000FF);

        applyStimulus(OP_LD, 3'b001, 32'h2, 32'h0);
        checkOutput("lh_data", load_data, 32'hFFFF80FF);

        applyStimulus(OP_LD, 3'b101, 32'h0, 32'h0);
        checkOutput("lhu_data", load_data, 32'h00007F01);

        applyStimulus(OP_LD, 3'b010, 32'h0, 32'h0);
        checkOutput("lw_data", load_data, 32'h80FF7F01);
        checkOutput("lw_wstrb", req_strb, 4'h0);

        applyStimulus(OP_ST, 3'b001, 32'h102, 32'h1234ABCD);
        checkOutput("sh_latency", lat, 2);
        checkOutput("sh_addr", req_addr, 32'h100);
        checkOutput("sh_wstrb", req_strb, 4'b1100);
        checkOutput("sh_wdata", req_wdata, 32'hABCDABCD);
        checkOutput("sh_we", req_we, 1);
        checkOutput("sh_keeps_load_data", load_data, 32'h80FF7F01);

        applyStimulus(OP_ST, 3'b000, 32'h101, 32'h000000A5);
        checkOutput("sb_wstrb", req_strb, 4'b0010);
        checkOutput("sb_wdata", req_wdata, 32'hA5A5A5A5);

        applyStimulus(OP_LD, 3'b010, 32'h100, 32'h0);
        checkOutput("lw_merged", load_data, 32'hABCDA500);

        applyStimulus(OP_LD, 3'b010, 32'h6, 32'h0);
        checkOutput("mis_latency", lat, 1);
        checkOutput("mis_fault", flt, 1);
        checkOutput("mis_code", code, 2'b01);
        checkOutput("mis_no_req", saw_req, 0);
        checkOutput("mis_keeps_load_data", load_data, 32'hABCDA500);

        applyStimulus(OP_LD, 3'b011, 32'h0, 32'h0);
        checkOutput("ill_latency", lat, 1);
        checkOutput("ill_code", code, 2'b10);
        checkOutput("ill_no_req", saw_req, 0);

        applyStimulus(OP_ST, 3'b100, 32'h0, 32'h0);
        checkOutput("ill_st_code", code, 2'b10);

        // Unknown opcode must not start an access
        @(posedge clk); #1;
        opcode = 5'b01100; func3 = 3'b000; addr = 32'h0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("ignored_busy", busy, 0);
        checkOutput("ignored_req", mem_req, 0);

        // Stalled grant: request held stable for 5 cycles
        hold_gnt = 1'b1;
        @(posedge clk); #1;
        opcode = OP_LD; func3 = 3'b010; addr = 32'h0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_req", mem_req, 1);
            checkOutput("stall_addr", mem_addr, 32'h0);
            checkOutput("stall_busy", busy, 1);
            @(posedge clk); #1;
        end
        hold_gnt = 1'b0;
        lat = 0;
        while (lat < 20 && !done) begin
            @(posedge clk); #1;
            lat++;
        end
        @(negedge clk);
        checkOutput("stall_done", done, 1);
        checkOutput("stall_fault", fault, 0);
        checkOutput("stall_data", load_data, 32'h80FF7F01);

        // Timeout instance: grant never comes
        @(posedge clk); #1;
        opcode = OP_LD; func3 = 3'b010; addr = 32'h0; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        lat = 1; reqs = 0;
        while (lat < 30) begin
            @(negedge clk);
            if (mem_req2) reqs++;
            if (done2) break;
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("to_req_cycles", reqs, 4);
        checkOutput("to_latency", lat, 5);
        checkOutput("to_done", done2, 1);
        checkOutput("to_fault", fault2, 1);
        checkOutput("to_code", fault_code2, 2'b11);
        checkOutput("to_req_dropped", mem_req2, 0);
        checkOutput("to_load_data", load_data2, 32'h0);

        // Reset while waiting for read data
        hold_rvalid = 1'b1;
        @(posedge clk); #1;
        opcode = OP_LD; func3 = 3'b010; addr = 32'h0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checkOutput("wr_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_req", mem_req, 0);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; hold_rvalid = 1'b0;
        @(posedge clk); #1;
        stray_rvalid = 1'b1;
        @(negedge clk);
        checkOutput("stray_done_a", done, 0);
        @(posedge clk); #1;
        stray_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("stray_done_b", done, 0);
        checkOutput("stray_busy", busy, 0);
        checkOutput("stray_load_data", load_data, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
